muu_dedup_blockformer: RTL and testbench
========================================

# muu_dedup_blockformer

Front end of the dedup hashing path. Takes a stream of value words, 64 bits per beat, and builds SHA-256-padded 512-bit message blocks. It drives the 512-bit block interface (data/valid/last/ready) consumed by the dedup hasher array. `block_last` marks the final block of each message, which is how the hasher array selects the next engine.

## Interface
Parameters:
- none. Widths are fixed: 64-bit input word, 512-bit block, 32-bit byte counter.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value_data`  in  64  message word. Byte j is at bits [63-8j -: 8]; byte 0 is first in the message.
- `value_valid`  in  1  word valid.
- `value_last`  in  1  last word of the message.
- `value_bytes`  in  3  valid bytes in the last word, left-justified. 0 means 8. Ignored when `value_last` is 0.
- `value_ready`  out  1  word accepted when `value_valid && value_ready`.
- `block_data`  out  512  block. Word k is at bits [511-64k -: 64].
- `block_valid`  out  1  block valid.
- `block_last`  out  1  final (length-carrying) block of the message.
- `block_ready`  in  1  block consumed when `block_valid && block_ready`.

## Operation
- **State machine:** FILL, HOLD, EXTRA. Internal registers:
  - assembly buffer `asm[0..7]` (64 bits each) and `asm_last`;
  - slot index `idx` (3 bits);
  - byte count `cnt` (32 bits);
  - flag `pad0`;
  - output register for `block_*`.
- **`value_ready`** = (state == FILL). It is never derived from `value_valid` or `value_last`.
- **FILL, word accepted:**
  - `asm[idx]` gets the word, with bytes at and above n masked to 0 (n = `value_bytes`, 0 read as 8).
  - `cnt` += 8 for a non-last word, or += n for the last word.
  - Non-last word, `idx` < 7: `idx` increments.
  - Non-last word, `idx` == 7: `asm_last` = 0, go to HOLD, then EXTRA is not taken (the next message word continues filling).
  - Last word, n < 8: byte n of `asm[idx]` = 0x80. Let p = `idx`.
  - Last word, n == 8: the 0x80 goes into word p = `idx`+1.
    - If p ≤ 7, `asm[p]` = 0x8000_0000_0000_0000.
    - If p == 8, set `pad0` = 1.
  - Completion with p ≤ 6:
    - words p+1..6 = 0;
    - `asm[7]` = bit length = {29'b0, cnt_final, 3'b0};
    - `asm_last` = 1;
    - go to HOLD.
  - Completion with p ≥ 7: `asm_last` = 0, go to HOLD, then EXTRA.
- **HOLD:**
  - When `!block_valid || block_ready`, copy `asm` into the output register.
  - Set `block_valid` = 1 and `block_last` = `asm_last`.
  - Then either go to EXTRA (when pending), or go to FILL with `idx` = 0 and all `asm` words cleared. After a final block, `cnt` = 0 and `pad0` = 0.
- **EXTRA:**
  - Build the extra block: word 0 = (`pad0` ? 0x80 followed by 56 zero bits : 0), words 1..6 = 0, word 7 = bit length, `asm_last` = 1.
  - Go to HOLD.
- **Output register:** `block_valid` clears on `block_ready` unless HOLD reloads it in the same cycle.
- **Wrap:** `cnt` wraps modulo 2^32. Messages of 2^32 bytes or more produce a wrong length field; this is unsupported and not flagged.
- **Reset (at any time, including mid-message):**
  - state = FILL, `idx` = 0, `cnt` = 0, `pad0` = 0, `asm` = 0;
  - `block_data` = 0, `block_valid` = 0, `block_last` = 0;
  - `value_ready` = 0 while `rst_n` is low, and 1 in the first cycle after release;
  - any partial message is discarded.

## Timing
- **Latency:** the word that completes a block is accepted at cycle t; `block_valid` rises at t+2 if the output register is free.
- **Throughput:** `value_ready` is low for 1 cycle (HOLD) per block when downstream is free, or 3 cycles when an EXTRA block is needed. That gives 8 words per 9 cycles steady state.
- **Backpressure:**
  - HOLD persists while `block_valid && !block_ready`. `value_ready` stays low.
  - `block_data` and `block_last` are stable while `block_valid && !block_ready`.
- **Back-to-back blocks:** HOLD may load a new block in the same cycle the previous one is consumed, so `block_valid` stays high with no bubble.

## Test plan
- **"abc":** one word 0x6162_63xx_xxxx_xxxx, `value_bytes` = 3, last.
  - Expect one block: word0 = 0x6162_6380_0000_0000, words1-6 = 0, word7 = 0x18, `block_last` = 1.
  - `block_valid` at t+2.
- **55 bytes:** 7 words, last with `value_bytes` = 7.
  - Expect a single block: word6 low byte = 0x80, word7 = 0x1B8, last = 1.
- **56 bytes:** 7 full words.
  - Expect block A: word7 = 0x8000_0000_0000_0000, last = 0.
  - Expect block B: words0-6 = 0, word7 = 0x1C0, last = 1.
- **64 bytes:** 8 full words.
  - Expect block A = data, last = 0.
  - Expect block B: word0 = 0x8000_0000_0000_0000, word7 = 0x200, last = 1.
  - Expect `value_ready` low for 3 cycles.
- **Backpressure:** two 3-byte messages back to back, `block_ready` held low for 20 cycles.
  - Expect `value_ready` low after the second word.
  - Expect the first block to be held stable.
  - Expect both blocks delivered in order, with no loss.
- **Reset mid-message:** assert `rst_n` low after 5 words of a 64-byte message.
  - Expect outputs at 0 during reset.
  - A following "abc" message must produce exactly the block from the first scenario, with no residue from the discarded message.

Source files
------------

// File: rtl/muu_dedup_blockformer.sv
// SHA-256 block former: packs 64-bit message words into padded 512-bit blocks,
// appending the 0x80 marker and the big-endian bit length of each message.
module muu_dedup_blockformer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [63:0]  value_data,
    input  logic         value_valid,
    input  logic         value_last,
    input  logic [2:0]   value_bytes,
    output logic         value_ready,
    output logic [511:0] block_data,
    output logic         block_valid,
    output logic         block_last,
    input  logic         block_ready
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_HOLD  = 2'd1,
        S_EXTRA = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;

    logic [63:0]  r_asm [8];
    logic [63:0]  w_asm_next [8];
    logic         r_asm_last;
    logic         w_asm_last_next;
    logic [2:0]   r_idx;
    logic [2:0]   w_idx_next;
    logic [31:0]  r_cnt;
    logic [31:0]  w_cnt_next;
    logic         r_pad0;
    logic         w_pad0_next;
    logic         r_extra;
    logic         w_extra_next;

    logic [511:0] r_block_data;
    logic         r_block_valid;
    logic         r_block_last;
    logic         w_load;

    logic [3:0]   w_n;
    logic [5:0]   w_mask_sh;
    logic [5:0]   w_pad_sh;
    logic [63:0]  w_word;
    logic [63:0]  w_word_pad;
    logic [31:0]  w_cnt_add;
    logic [3:0]   w_p;
    logic [511:0] w_asm_flat;

    function automatic logic [63:0] f_bitlen(input logic [31:0] c);
        return {29'd0, c, 3'b000};
    endfunction

    // Valid byte count of the incoming word; non-last words are always full.
    assign w_n        = (value_last && (value_bytes != 3'd0)) ? {1'b0, value_bytes} : 4'd8;
    assign w_mask_sh  = {3'(4'd8 - w_n), 3'b000};
    assign w_pad_sh   = {3'(4'd7 - w_n), 3'b000};
    assign w_word     = value_data & (64'hFFFF_FFFF_FFFF_FFFF << w_mask_sh);
    assign w_word_pad = w_word | (64'h0000_0000_0000_0080 << w_pad_sh);
    assign w_cnt_add  = r_cnt + {28'd0, w_n};
    // Slot holding the 0x80 marker; 8 means it spills into an extra block.
    assign w_p        = (w_n == 4'd8) ? ({1'b0, r_idx} + 4'd1) : {1'b0, r_idx};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_flat
            assign w_asm_flat[511-64*gi -: 64] = r_asm[gi];
        end
    endgenerate

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_cnt_next      = r_cnt;
        w_pad0_next     = r_pad0;
        w_extra_next    = r_extra;
        w_asm_last_next = r_asm_last;
        w_load          = 1'b0;
        for (int k = 0; k < 8; k++) begin
            w_asm_next[k] = r_asm[k];
        end

        case (r_state)
            S_FILL: begin
                if (value_valid) begin
                    w_cnt_next = w_cnt_add;
                    if (!value_last) begin
                        w_asm_next[r_idx] = w_word;
                        if (r_idx != 3'd7) begin
                            w_idx_next = r_idx + 3'd1;
                        end else begin
                            w_asm_last_next = 1'b0;
                            w_extra_next    = 1'b0;
                            w_state_next    = S_HOLD;
                        end
                    end else begin
                        w_asm_next[r_idx] = (w_n == 4'd8) ? w_word : w_word_pad;
                        if (w_p == 4'd8) begin
                            w_pad0_next = 1'b1;
                        end else if (w_n == 4'd8) begin
                            w_asm_next[w_p[2:0]] = 64'h8000_0000_0000_0000;
                        end
                        if (w_p <= 4'd6) begin
                            for (int k = 0; k < 7; k++) begin
                                if (4'(k) > w_p) begin
                                    w_asm_next[k] = 64'd0;
                                end
                            end
                            w_asm_next[7]   = f_bitlen(w_cnt_add);
                            w_asm_last_next = 1'b1;
                            w_extra_next    = 1'b0;
                        end else begin
                            // No room for the length word: finish in an extra block.
                            w_asm_last_next = 1'b0;
                            w_extra_next    = 1'b1;
                        end
                        w_state_next = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (!r_block_valid || block_ready) begin
                    w_load = 1'b1;
                    if (r_extra) begin
                        w_state_next = S_EXTRA;
                    end else begin
                        w_state_next = S_FILL;
                        w_idx_next   = 3'd0;
                        for (int k = 0; k < 8; k++) begin
                            w_asm_next[k] = 64'd0;
                        end
                        if (r_asm_last) begin
                            w_cnt_next  = 32'd0;
                            w_pad0_next = 1'b0;
                        end
                    end
                end
            end

            S_EXTRA: begin
                w_asm_next[0] = r_pad0 ? 64'h8000_0000_0000_0000 : 64'd0;
                for (int k = 1; k < 7; k++) begin
                    w_asm_next[k] = 64'd0;
                end
                w_asm_next[7]   = f_bitlen(r_cnt);
                w_asm_last_next = 1'b1;
                w_extra_next    = 1'b0;
                w_state_next    = S_HOLD;
            end

            default: begin
                w_state_next = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FILL;
            r_idx      <= 3'd0;
            r_cnt      <= 32'd0;
            r_pad0     <= 1'b0;
            r_extra    <= 1'b0;
            r_asm_last <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_asm[k] <= 64'd0;
            end
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_cnt      <= w_cnt_next;
            r_pad0     <= w_pad0_next;
            r_extra    <= w_extra_next;
            r_asm_last <= w_asm_last_next;
            for (int k = 0; k < 8; k++) begin
                r_asm[k] <= w_asm_next[k];
            end
        end
    end

    // Reload in HOLD takes priority so consecutive blocks leave no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_block_data  <= 512'd0;
            r_block_valid <= 1'b0;
            r_block_last  <= 1'b0;
        end else if (w_load) begin
            r_block_data  <= w_asm_flat;
            r_block_valid <= 1'b1;
            r_block_last  <= r_asm_last;
        end else if (block_ready) begin
            r_block_valid <= 1'b0;
        end
    end

    assign value_ready = (r_state == S_FILL) && rst_n;
    assign block_data  = r_block_data;
    assign block_valid = r_block_valid;
    assign block_last  = r_block_last;

endmodule

// File: tb/tb_muu_dedup_blockformer.sv
// Scoreboard bench for muu_dedup_blockformer: an independent SHA-256 padding
// model queues expected blocks; a negedge monitor compares consumed blocks.
module tb_muu_dedup_blockformer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  value_data;
    logic         value_valid;
    logic         value_last;
    logic [2:0]   value_bytes;
    logic         value_ready;
    logic [511:0] block_data;
    logic         block_valid;
    logic         block_last;
    logic         block_ready;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [511:0] data;
        logic         last;
    } blk_t;

    blk_t        exp_q[$];
    blk_t        mon_exp;
    byte unsigned msg[$];

    always #5 clk = ~clk;

    muu_dedup_blockformer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_data  (value_data),
        .value_valid (value_valid),
        .value_last  (value_last),
        .value_bytes (value_bytes),
        .value_ready (value_ready),
        .block_data  (block_data),
        .block_valid (block_valid),
        .block_last  (block_last),
        .block_ready (block_ready)
    );

    // Monitor: every consumed block is popped against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && block_valid && block_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_block: got last=%0b data=%h, required no block", block_last, block_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (block_data !== mon_exp.data || block_last !== mon_exp.last) begin
                    bad++;
                    $display("FAIL block_compare: got last=%0b data=%h", block_last, block_data);
                    $display("     required last=%0b data=%h", mon_exp.last, mon_exp.data);
                end else begin
                    $display("block ok: last=%0b word0=%h word7=%h", block_last, block_data[511 -: 64], block_data[63:0]);
                end
            end
        end
    end

    task automatic push_expected();
        byte unsigned pad[$];
        logic [63:0]  bits;
        blk_t         b;
        int           nblk;
        pad = msg;
        pad.push_back(8'h80);
        while ((pad.size() % 64) != 56) pad.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 0; i < 8; i++) pad.push_back(bits[63-8*i -: 8]);
        nblk = pad.size() / 64;
        for (int bi = 0; bi < nblk; bi++) begin
            b.data = '0;
            for (int i = 0; i < 64; i++) b.data[511-8*i -: 8] = pad[bi*64+i];
            b.last = (bi == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic fill_random(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic send_word(input logic [63:0] d, input logic l, input logic [2:0] nb);
        bit done = 1'b0;
        value_data  = d;
        value_last  = l;
        value_bytes = nb;
        value_valid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (value_ready) done = 1'b1;
        end
        @(posedge clk);
        #1;
        value_valid = 1'b0;
        value_last  = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: value_ready=0 for 200 cycles, required 1");
        end
    endtask

    // Drives word w of msg; bytes past the message end carry garbage.
    task automatic send_msg_word(input int w);
        logic [63:0] word;
        int          len;
        int          nw;
        int          k;
        len = msg.size();
        nw  = (len + 7) / 8;
        for (int i = 0; i < 8; i++) begin
            k = w * 8 + i;
            word[63-8*i -: 8] = (k < len) ? msg[k] : 8'($urandom);
        end
        send_word(word, (w == nw - 1), 3'(len % 8));
    endtask

    task automatic send_msg();
        int nw;
        nw = (msg.size() + 7) / 8;
        for (int w = 0; w < nw; w++) send_msg_word(w);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d blocks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (value_ready !== 1'b0 || block_valid !== 1'b0 || block_last !== 1'b0 || block_data !== 512'd0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b last=%0b data_nz=%0b, required all 0",
                     value_ready, block_valid, block_last, |block_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (value_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %0b, required 1", value_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        push_expected();
        send_msg();
        @(negedge clk);
        total++;
        if (block_valid !== 1'b0 || value_ready !== 1'b0) begin
            bad++;
            $display("FAIL abc_t1: valid=%0b ready=%0b, required 0 0", block_valid, value_ready);
        end
        @(negedge clk);
        total++;
        if (block_valid !== 1'b1 || block_last !== 1'b1 ||
            block_data[511 -: 64] !== 64'h6162_6380_0000_0000 || block_data[63:0] !== 64'h18) begin
            bad++;
            $display("FAIL abc_t2: valid=%0b last=%0b w0=%h w7=%h, required 1 1 6162638000000000 18",
                     block_valid, block_last, block_data[511 -: 64], block_data[63:0]);
        end
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    task automatic test_len(input int len, input int exp_low);
        int low;
        fill_random(len);
        push_expected();
        send_msg();
        low = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (value_ready) break;
            low++;
        end
        total++;
        if (low != exp_low) begin
            bad++;
            $display("FAIL ready_low_len%0d: got %0d cycles, required %0d", len, low, exp_low);
        end
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    task automatic test_backpressure();
        blk_t first;
        block_ready = 1'b0;
        fill_random(3);
        push_expected();
        first = exp_q[0];
        send_msg();
        fill_random(3);
        push_expected();
        send_msg();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if (value_ready !== 1'b0 || block_valid !== 1'b1 || block_last !== first.last || block_data !== first.data) begin
                bad++;
                $display("FAIL bp_hold cyc%0d: ready=%0b valid=%0b last=%0b w0=%h, required 0 1 1 %h",
                         c, value_ready, block_valid, block_last, block_data[511 -: 64], first.data[511 -: 64]);
            end
        end
        @(posedge clk);
        #1;
        block_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (block_valid !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back: valid=%0b after first consume, required 1", block_valid);
        end
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    task automatic test_random();
        for (int m = 0; m < 6; m++) begin
            fill_random(int'($urandom_range(1, 140)));
            push_expected();
            send_msg();
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        fill_random(64);
        for (int w = 0; w < 5; w++) send_msg_word(w);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (value_ready !== 1'b0 || block_valid !== 1'b0 || block_last !== 1'b0 || block_data !== 512'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: ready=%0b valid=%0b last=%0b data_nz=%0b, required all 0",
                     value_ready, block_valid, block_last, |block_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_abc();
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        value_data  = '0;
        value_valid = 1'b0;
        value_last  = 1'b0;
        value_bytes = 3'd0;
        block_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_abc();
        test_len(55, 1);
        test_len(56, 3);
        test_len(64, 3);
        test_len(120, 3);
        test_len(17, 1);
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
